// File: rtl/mealy101_pkg.sv
// Shared types and defaults for the 1-0-1 Mealy sequence detector.
// Holds the 2-bit state encoding and the default detection-counter width.
package mealy101_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_1    = 2'd1,
        S_10   = 2'd2
    } state_t;

    localparam int CNT_W_DEF = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-high reset.
// It advances by one on each clock where inc_i is high and holds at all-ones.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/mealy_101_seq_detector.sv
// Overlapping 1-0-1 serial detector, Mealy output in the same cycle as the final 1.
// Defining MEALY101_DET_CNT_EN adds a saturating detection counter on port det_cnt.
module mealy_101_seq_detector
    import mealy101_pkg::*;
`ifdef MEALY101_DET_CNT_EN
#(
    parameter int CNT_W = CNT_W_DEF
)
`endif
(
    input  logic             clk,
    input  logic             reset,
    input  logic             in,
    output logic             out
`ifdef MEALY101_DET_CNT_EN
    ,
    output logic [CNT_W-1:0] det_cnt
`endif
);

    state_t state_q;
    state_t state_d;
    logic   hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The final 1 of a match also opens the next match, so a hit lands in S_1.
    always_comb begin
        state_d = S_IDLE;
        hit     = 1'b0;
        case (state_q)
            S_IDLE: state_d = in ? S_1 : S_IDLE;
            S_1:    state_d = in ? S_1 : S_10;
            S_10: begin
                state_d = in ? S_1 : S_IDLE;
                hit     = in;
            end
            default: begin
                state_d = S_IDLE;
                hit     = 1'b0;
            end
        endcase
    end

    assign out = hit && !reset;

`ifdef MEALY101_DET_CNT_EN
    sat_counter #(
        .W (CNT_W)
    ) u_det_cnt (
        .clk   (clk),
        .rst_i (reset),
        .inc_i (out),
        .cnt_o (det_cnt)
    );
`endif

endmodule

// File: tb/tb_mealy_101_seq_detector.sv
// Self-checking bench for the 1-0-1 detector: directed cases plus random bits against a history model.
// With MEALY101_DET_CNT_EN defined, the DUT is built with a 2-bit counter that is checked too.
module tb_mealy_101_seq_detector;

    localparam int TB_CNT_W = 2;

    logic clk;
    logic reset;
    logic din;
    logic dout;
`ifdef MEALY101_DET_CNT_EN
    logic [TB_CNT_W-1:0] det_cnt;
`endif

    int n_checks;
    int n_errors;

    // Reference: every bit accepted since the last reset, plus a saturating hit count.
    bit hist[$];
    int model_cnt;

    initial clk = 1'b0;
    always #10 clk = ~clk;

`ifdef MEALY101_DET_CNT_EN
    mealy_101_seq_detector #(
        .CNT_W (TB_CNT_W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .in      (din),
        .out     (dout),
        .det_cnt (det_cnt)
    );
`else
    mealy_101_seq_detector dut (
        .clk   (clk),
        .reset (reset),
        .in    (din),
        .out   (dout)
    );
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit model_out(input bit b);
        int n;
        n = hist.size();
        return (n >= 2) && hist[n-2] && !hist[n-1] && b;
    endfunction

    function automatic void model_reset();
        hist.delete();
        model_cnt = 0;
    endfunction

    // Drive b after the falling edge, check out just before the rising edge, then commit.
    task automatic send(input bit b, input bit exp, input string tag);
        bit hit;
        @(negedge clk);
        din = b;
        #9;
        check(tag, {31'd0, dout}, {31'd0, exp});
        hit = model_out(b);
        @(posedge clk);
        hist.push_back(b);
        if (hit && model_cnt < (1 << TB_CNT_W) - 1) model_cnt++;
        #1;
`ifdef MEALY101_DET_CNT_EN
        check({tag, "_cnt"}, {30'd0, det_cnt}, model_cnt);
`endif
    endtask

    task automatic flush();
        send(1'b0, 1'b0, "flush");
        send(1'b0, 1'b0, "flush");
    endtask

    initial begin
        bit b;
        n_checks = 0;
        n_errors = 0;
        model_reset();
        reset = 1'b1;
        din   = 1'b0;

        // Held in reset with toggling input: nothing may be reported.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            din = ~din;
            #9;
            check("rst_hold", {31'd0, dout}, 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        din   = 1'b1;
        #1;
`ifdef MEALY101_DET_CNT_EN
        check("rst_cnt", {30'd0, det_cnt}, 32'd0);
`endif
        @(posedge clk);
        hist.push_back(1'b1);
        #1;
        flush();

        send(1'b1, 1'b0, "basic_b1");
        send(1'b0, 1'b0, "basic_b2");
        send(1'b1, 1'b1, "basic_b3");
        flush();

        send(1'b1, 1'b0, "ovl_b1");
        send(1'b0, 1'b0, "ovl_b2");
        send(1'b1, 1'b1, "ovl_b3");
        send(1'b0, 1'b0, "ovl_b4");
        send(1'b1, 1'b1, "ovl_b5");
        flush();

        send(1'b1, 1'b0, "ovl2_b1");
        send(1'b0, 1'b0, "ovl2_b2");
        send(1'b1, 1'b1, "ovl2_b3");
        send(1'b1, 1'b0, "ovl2_b4");
        send(1'b0, 1'b0, "ovl2_b5");
        send(1'b1, 1'b1, "ovl2_b6");
        flush();

        send(1'b0, 1'b0, "nm_b1");
        send(1'b0, 1'b0, "nm_b2");
        send(1'b1, 1'b0, "nm_b3");
        send(1'b1, 1'b0, "nm_b4");
        send(1'b0, 1'b0, "nm_b5");
        send(1'b0, 1'b0, "nm_b6");
        send(1'b1, 1'b0, "nm_b7");
        flush();

        send(1'b1, 1'b0, "nm2_b1");
        send(1'b1, 1'b0, "nm2_b2");
        send(1'b0, 1'b0, "nm2_b3");
        send(1'b1, 1'b1, "nm2_b4");
        flush();

        // 1,0 then a reset pulse entirely between clock edges while in=1.
        send(1'b1, 1'b0, "mid_b1");
        send(1'b0, 1'b0, "mid_b2");
        @(negedge clk);
        din   = 1'b1;
        reset = 1'b1;
        #2;
        check("mid_rst_gate", {31'd0, dout}, 32'd0);
`ifdef MEALY101_DET_CNT_EN
        check("mid_rst_cnt", {30'd0, det_cnt}, 32'd0);
`endif
        #3;
        reset = 1'b0;
        model_reset();
        #4;
        check("mid_after", {31'd0, dout}, 32'd0);
        @(posedge clk);
        hist.push_back(1'b1);
        #1;
        send(1'b0, 1'b0, "mid_b4");
        send(1'b1, 1'b1, "mid_b5");
        flush();

`ifdef MEALY101_DET_CNT_EN
        // Five overlapping matches from a clean count: 1,2,3,3,3.
        @(negedge clk);
        reset = 1'b1;
        #2;
        check("cnt_rst", {30'd0, det_cnt}, 32'd0);
        reset = 1'b0;
        model_reset();
        send(1'b1, 1'b0, "sat_b1");
        for (int k = 0; k < 5; k++) begin
            send(1'b0, 1'b0, "sat_z");
            send(1'b1, 1'b1, "sat_h");
            check("sat_seq", {30'd0, det_cnt}, (k < 3) ? k + 1 : 3);
        end
        flush();
`endif

        for (int i = 0; i < 400; i++) begin
            b = ($urandom_range(0, 3) != 0) ? ~hist[hist.size()-1] : hist[hist.size()-1];
            send(b, model_out(b), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
